// File: rtl/hazard_pkg.sv
// hazard_pkg -- shared constants for the pipeline hazard controller.
//   Timing encodings for tuse (cycles until a source operand is consumed)
//   and tnew (cycles until a produced result can be forwarded), default MDU
//   latencies, and a helper that sizes the MDU busy counter.
package hazard_pkg;

  // tuse encodings: where the consuming instruction needs its operand
  localparam logic [1:0] TUSE_D = 2'd0;
  localparam logic [1:0] TUSE_E = 2'd1;
  localparam logic [1:0] TUSE_M = 2'd2;

  // tnew encodings: how many cycles until the producer's result is ready
  localparam logic [1:0] TNEW_NOW = 2'd0;
  localparam logic [1:0] TNEW_1   = 2'd1;
  localparam logic [1:0] TNEW_2   = 2'd2;

  // default MDU occupancy in cycles
  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  // Width needed to hold the larger of the two MDU latencies.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_busy_ctr.sv
// mdu_busy_ctr -- tracks how long the multiply/divide unit stays occupied.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high; abandons any in-flight count
//   start  : operation issued this cycle (ignored while busy)
//   is_div : issued operation is a divide (else multiply)
//   busy   : high while the counter is nonzero
module mdu_busy_ctr
  import hazard_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int CNT_W = cnt_width(MULT_CYC, DIV_CYC);
  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);

  if (MULT_CYC < 1 || DIV_CYC < 1) begin : g_bad_cfg
    $error("mdu_busy_ctr: MULT_CYC and DIV_CYC must both be at least 1");
  end

  logic [CNT_W-1:0] cnt;

  // A start arriving while busy neither reloads nor extends the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (start && (cnt == '0)) begin
      cnt <= is_div ? DIV_LD : MULT_LD;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- decode-stage stall/flush generation for a 5-stage pipeline.
//   Register hazards: a D-stage source that matches the E or M destination
//   stalls when it is needed (tuse) before the producer can forward (tnew).
//   Register 0 never hazards. MDU hazards stall any mult/div/hi/lo
//   instruction while the MDU is busy or being issued in E.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   rs_D, rt_D            : D-stage source addresses
//   use_rs_D, use_rt_D    : source actually read
//   tuse_rs_D, tuse_rt_D  : cycles until each source is consumed
//   a3_E, tnew_E          : E-stage destination and its readiness
//   a3_M, tnew_M          : M-stage destination and its readiness
//   md_start_E, md_is_div_E : MDU issue in E and its kind
//   md_use_D              : D instruction touches the MDU
//   stall, flush_E        : freeze F/D, bubble into D/E (identical)
//   md_busy               : MDU operation in flight
//   stall_cnt             : saturating stall-cycle counter, present only
//                           when HAZARD_STALL_CNT_EN is defined
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_D,
  input  logic [REG_AW-1:0] rt_D,
  input  logic              use_rs_D,
  input  logic              use_rt_D,
  input  logic [1:0]        tuse_rs_D,
  input  logic [1:0]        tuse_rt_D,
  input  logic [REG_AW-1:0] a3_E,
  input  logic [1:0]        tnew_E,
  input  logic [REG_AW-1:0] a3_M,
  input  logic [1:0]        tnew_M,
  input  logic              md_start_E,
  input  logic              md_is_div_E,
  input  logic              md_use_D,
  output logic              stall,
  output logic              flush_E,
  output logic              md_busy
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  // One source operand against both producer stages; E and M are equal peers.
  function automatic logic src_hazard(
    input logic              use_src,
    input logic [REG_AW-1:0] src,
    input logic [1:0]        tuse,
    input logic [REG_AW-1:0] dst_e,
    input logic [1:0]        tn_e,
    input logic [REG_AW-1:0] dst_m,
    input logic [1:0]        tn_m
  );
    logic hit_e, hit_m;
    hit_e = (src == dst_e) && (tuse < tn_e);
    hit_m = (src == dst_m) && (tuse < tn_m);
    return use_src && (src != '0) && (hit_e || hit_m);
  endfunction

  logic rs_haz, rt_haz, md_haz;

  mdu_busy_ctr #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_busy (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start_E),
    .is_div (md_is_div_E),
    .busy   (md_busy)
  );

  always_comb begin
    rs_haz  = src_hazard(use_rs_D, rs_D, tuse_rs_D, a3_E, tnew_E, a3_M, tnew_M);
    rt_haz  = src_hazard(use_rt_D, rt_D, tuse_rt_D, a3_E, tnew_E, a3_M, tnew_M);
    md_haz  = md_use_D && (md_busy || md_start_E);
    stall   = rs_haz || rt_haz || md_haz;
    flush_E = stall;
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- directed and randomized checks of hazard_ctrl against a
// timestamp-based reference model of the MDU and a rule-based stall model.
// Build with +define+HAZARD_STALL_CNT_EN to also exercise stall_cnt.
module tb_hazard_ctrl;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] rs_D, rt_D, a3_E, a3_M;
  logic          use_rs_D, use_rt_D;
  logic [1:0]    tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
  logic          md_start_E, md_is_div_E, md_use_D;
  logic          stall, flush_E, md_busy;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int busy_until = -1;   // last cycle index in which the MDU is occupied
  int busy_seen, stall_seen;
  longint exp_cnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(AW), .MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .use_rs_D(use_rs_D), .use_rt_D(use_rt_D),
    .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .a3_E(a3_E), .tnew_E(tnew_E), .a3_M(a3_M), .tnew_M(tnew_M),
    .md_start_E(md_start_E), .md_is_div_E(md_is_div_E), .md_use_D(md_use_D),
    .stall(stall), .flush_E(flush_E), .md_busy(md_busy)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_busy();
    return cyc <= busy_until;
  endfunction

  function automatic bit model_stall();
    bit h = 0;
    if (use_rs_D && rs_D != 0 &&
        ((rs_D == a3_E && tuse_rs_D < tnew_E) || (rs_D == a3_M && tuse_rs_D < tnew_M))) h = 1;
    if (use_rt_D && rt_D != 0 &&
        ((rt_D == a3_E && tuse_rt_D < tnew_E) || (rt_D == a3_M && tuse_rt_D < tnew_M))) h = 1;
    if (md_use_D && (model_busy() || md_start_E)) h = 1;
    return h;
  endfunction

  task automatic clear_inputs();
    rs_D = 0; rt_D = 0; a3_E = 0; a3_M = 0;
    use_rs_D = 0; use_rt_D = 0; tuse_rs_D = 0; tuse_rt_D = 0;
    tnew_E = 0; tnew_M = 0; md_start_E = 0; md_is_div_E = 0; md_use_D = 0;
  endtask

  // Checks the current cycle at the falling edge, then advances the model
  // across the next rising edge; returns #1 after that edge.
  task automatic cycle_check(input string tag);
    bit s;
    @(negedge clk);
    s = model_stall();
    check({tag, "_stall"}, 32'(stall), 32'(s));
    check({tag, "_flush"}, 32'(flush_E), 32'(s));
    check({tag, "_busy"}, 32'(md_busy), 32'(model_busy()));
`ifdef HAZARD_STALL_CNT_EN
    check({tag, "_scnt"}, stall_cnt, 32'(exp_cnt));
`endif
    if (md_busy === 1'b1) busy_seen++;
    if (stall === 1'b1) stall_seen++;
    @(posedge clk);
    if (s && exp_cnt != 64'hFFFF_FFFF) exp_cnt++;
    if (md_start_E && !model_busy()) busy_until = cyc + (md_is_div_E ? 10 : 5);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_busy", 32'(md_busy), 32'd0);
`ifdef HAZARD_STALL_CNT_EN
    check("rst_scnt", stall_cnt, 32'd0);
`endif
    busy_until = cyc - 1;
    exp_cnt = 0;
    reset = 1'b0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    #2;
    check("init_busy", 32'(md_busy), 32'd0);
    check("init_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc = 0;

    // rs vs E: needed now, ready in 2 -> stall; needed in 2 -> no stall
    a3_E = 8; tnew_E = 2; rs_D = 8; use_rs_D = 1; tuse_rs_D = 0;
    cycle_check("rsE_t0");
    check("rsE_t0_const", 32'(stall), 32'd1);
    tuse_rs_D = 2;
    cycle_check("rsE_t2");
    check("rsE_t2_const", 32'(stall), 32'd0);

    // register 0 never hazards
    clear_inputs();
    a3_E = 0; tnew_E = 2; rs_D = 0; use_rs_D = 1; tuse_rs_D = 0;
    cycle_check("r0");
    check("r0_const", 32'(stall), 32'd0);

    // rt vs M
    clear_inputs();
    a3_M = 9; tnew_M = 1; rt_D = 9; use_rt_D = 1; tuse_rt_D = 0;
    cycle_check("rtM_t1");
    check("rtM_t1_const", 32'(stall), 32'd1);
    tnew_M = 0;
    cycle_check("rtM_t0");
    check("rtM_t0_const", 32'(stall), 32'd0);

    // multiply: busy 5 cycles, stall issue cycle + 5
    clear_inputs();
    md_use_D = 1; md_start_E = 1; md_is_div_E = 0;
    busy_seen = 0; stall_seen = 0;
    cycle_check("mul_iss");
    md_start_E = 0;
    for (int i = 0; i < 7; i++) cycle_check("mul_run");
    check("mul_busy_len", 32'(busy_seen), 32'd5);
    check("mul_stall_len", 32'(stall_seen), 32'd6);

    // divide aborted by reset after 3 busy cycles
    clear_inputs();
    md_start_E = 1; md_is_div_E = 1;
    cycle_check("div_iss");
    md_start_E = 0;
    for (int i = 0; i < 3; i++) cycle_check("div_run");
    do_reset();
    cycle_check("div_post_rst");

    // second start while busy leaves the divide length unchanged
    clear_inputs();
    busy_seen = 0;
    md_start_E = 1; md_is_div_E = 1;
    cycle_check("div2_iss");
    md_is_div_E = 0;   // restart attempt (multiply) while busy
    cycle_check("div2_restart");
    md_start_E = 0;
    for (int i = 0; i < 11; i++) cycle_check("div2_run");
    check("div2_busy_len", 32'(busy_seen), 32'd10);

`ifdef HAZARD_STALL_CNT_EN
    clear_inputs();
    do_reset();
    a3_E = 3; tnew_E = 1; rs_D = 3; use_rs_D = 1; tuse_rs_D = 0;
    for (int i = 0; i < 7; i++) cycle_check("scnt7");
    clear_inputs();
    cycle_check("scnt7_idle");
    check("scnt7_const", stall_cnt, 32'd7);
    force dut.stall_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt;
    exp_cnt = 64'hFFFF_FFFD;
    a3_E = 3; tnew_E = 1; rs_D = 3; use_rs_D = 1; tuse_rs_D = 0;
    for (int i = 0; i < 5; i++) cycle_check("scnt_sat");
    check("scnt_sat_const", stall_cnt, 32'hFFFF_FFFF);
`endif

    // randomized traffic over a small register window to provoke matches
    clear_inputs();
    for (int i = 0; i < 600; i++) begin
      rs_D = AW'($urandom_range(0, 3));
      rt_D = AW'($urandom_range(0, 3));
      a3_E = AW'($urandom_range(0, 3));
      a3_M = AW'($urandom_range(0, 3));
      use_rs_D = 1'($urandom_range(0, 1));
      use_rt_D = 1'($urandom_range(0, 1));
      tuse_rs_D = 2'($urandom_range(0, 2));
      tuse_rt_D = 2'($urandom_range(0, 2));
      tnew_E = 2'($urandom_range(0, 2));
      tnew_M = 2'($urandom_range(0, 1));
      md_start_E = ($urandom_range(0, 7) == 0);
      md_is_div_E = 1'($urandom_range(0, 1));
      md_use_D = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) do_reset();
      cycle_check("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, meaning register-address width (2**REG_AW architectural registers).
REQ-002 SHALL have parameter MULT_CYC, default 5, meaning MDU busy cycles for a multiply.
REQ-003 SHALL have parameter DIV_CYC, default 10, meaning MDU busy cycles for a divide.
REQ-004 SHALL have ports, one per line as name  direction  width  meaning:
clk  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-high.
rs_D  in  REG_AW  D-stage rs address.
rt_D  in  REG_AW  D-stage rt address.
use_rs_D  in  1  D instruction reads rs.
use_rt_D  in  1  D instruction reads rt.
tuse_rs_D  in  2  cycles until rs is consumed (0 = in D).
tuse_rt_D  in  2  cycles until rt is consumed.
a3_E  in  REG_AW  E-stage destination register.
tnew_E  in  2  cycles until the E result is forwardable.
a3_M  in  REG_AW  M-stage destination register.
tnew_M  in  2  cycles until the M result is forwardable.
md_start_E  in  1  mult/div issued in E this cycle.
md_is_div_E  in  1  issued operation is a divide.
md_use_D  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
stall  out  1  freeze PC and F/D register.
flush_E  out  1  load a bubble into D/E.
md_busy  out  1  MDU operation in flight.
stall_cnt  out  32  stall-cycle count (present only with macro).

Function
REQ-005 SHALL assert a register hazard for rs when use_rs_D=1, rs_D!=0, rs_D==a3_E and tuse_rs_D<tnew_E; rt is checked identically.
REQ-006 SHALL assert the same hazard against M when the address matches a3_M and tuse<tnew_M.
REQ-007 SHALL never report a hazard on register 0.
REQ-008 SHALL assert an MDU hazard when md_use_D=1 and (md_busy=1 or md_start_E=1).
REQ-009 SHALL drive stall combinationally as the OR of all hazards, with zero-cycle latency.
REQ-010 SHALL drive flush_E equal to stall.
REQ-011 SHALL hold a busy counter: on md_start_E=1 with md_busy=0, load DIV_CYC if md_is_div_E=1, else MULT_CYC.
REQ-012 SHALL decrement the busy counter by 1 each cycle while it is nonzero and no load occurs.
REQ-013 SHALL drive md_busy=1 exactly when the counter is nonzero; md_start_E at edge t gives md_busy high for cycles t+1..t+N.
REQ-014 SHALL ignore md_start_E while md_busy=1: no reload, no extension.
REQ-015 SHALL size the counter to hold max(MULT_CYC,DIV_CYC) and reject values below 1 at elaboration.
REQ-016 SHALL let the M-stage match take no priority over the E-stage match; either one alone causes a stall.

Reset
REQ-017 SHALL clear the busy counter, md_busy and stall_cnt immediately on reset assertion, independent of clk.
REQ-018 SHALL abandon any in-flight MDU count on reset mid-operation; md_busy reads 0 in the first cycle after release.
REQ-019 SHALL keep stall and flush_E purely combinational from the inputs during and after reset.

Configuration
REQ-020 SHALL, when HAZARD_STALL_CNT_EN is defined, provide stall_cnt: +1 on each rising edge with stall=1, saturating at 32'hFFFF_FFFF.
REQ-021 SHALL, when HAZARD_STALL_CNT_EN is undefined, omit the stall_cnt port and its register entirely.

Structure
REQ-022 SHALL place tuse/tnew encoding constants and default MULT_CYC/DIV_CYC in shared package hazard_pkg.
REQ-023 SHALL implement the busy counter in sub-module mdu_busy_ctr (ports clk, reset, start, is_div, busy).

Verification
REQ-024 SHALL cover: a3_E=8, tnew_E=2, rs_D=8, use_rs_D=1, tuse_rs_D=0 -> stall=1, flush_E=1; with tuse_rs_D=2 -> stall=0.
REQ-025 SHALL cover: a3_E=0, tnew_E=2, rs_D=0, use_rs_D=1, tuse_rs_D=0 -> stall=0.
REQ-026 SHALL cover: a3_M=9, tnew_M=1, rt_D=9, use_rt_D=1, tuse_rt_D=0 -> stall=1; with tnew_M=0 -> stall=0.
REQ-027 SHALL cover: md_start_E=1, md_is_div_E=0 for one cycle -> md_busy high exactly 5 cycles; md_use_D=1 held throughout -> stall high for the issue cycle plus those 5 cycles.
REQ-028 SHALL cover: divide started, reset pulsed after 3 cycles -> md_busy=0 immediately; a second md_start_E issued while busy -> busy length unchanged.
REQ-029 SHALL cover: with HAZARD_STALL_CNT_EN, 7 stall cycles -> stall_cnt=7; preload near all-ones -> stall_cnt saturates at 32'hFFFF_FFFF.
